multicycle_ctrl_fsm: RTL and testbench

Parametrised main control FSM for the multicycle RISC-V core. It replaces the fixed nine-state LW/SW/R-type/BEQ controller. It adds I-type ALU, BNE, LUI and (optional) JAL/JALR support, configurable memory wait states, and a sticky illegal-opcode trap. It sits between the instruction register (opcode/funct3) and the datapath multiplexer and enable inputs.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 70 +++++++
 rtl/multicycle_ctrl_fsm_if.sv | 21 ++
 rtl/multicycle_ctrl_fsm_mem_wait_ctr.sv | 35 +++
 rtl/multicycle_ctrl_fsm.sv | 149 ++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types for the multicycle control FSM: state encoding, opcode
// constants, datapath select encodings and the registered output bundle.
// Optional feature macro: CTRL_JUMP_EN (adds the JAL/JALR states).
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_LUI,
`ifdef CTRL_JUMP_EN
        S_JAL, S_JALR,
`endif
        S_TRAP
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_RTYPE = 2'b10, ALU_ITYPE = 2'b11} alu_op_e;
    typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_RS1 = 2'b01, SRCA_ZERO = 2'b10} src_a_e;
    typedef enum logic [1:0] {SRCB_RS2 = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10} src_b_e;
    typedef enum logic [1:0] {M2R_ALU = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10} m2r_e;
    typedef enum logic [1:0] {PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01} pcsrc_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    iord;
        logic    ir_write;
        logic    pc_write;
        logic    pc_write_cond;
        logic    branch_ne;
        logic    illegal;
        src_a_e  alu_src_a;
        src_b_e  alu_src_b;
        alu_op_e alu_op;
        m2r_e    mem_to_reg;
        pcsrc_e  pc_source;
    } ctrl_out_t;

    // DECODE dispatch; unknown opcodes and non-BEQ/BNE branches trap
    function automatic state_e decode_op(logic [6:0] op, logic [2:0] f3);
        state_e s;
        case (op)
            OP_LOAD, OP_STORE: s = S_MEMADR;
            OP_RTYPE:          s = S_EXEC_R;
            OP_ITYPE:          s = S_EXEC_I;
            OP_BRANCH:         s = (f3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
            OP_LUI:            s = S_LUI;
`ifdef CTRL_JUMP_EN
            OP_JAL:            s = S_JAL;
            OP_JALR:           s = S_JALR;
`endif
            default:           s = S_TRAP;
        endcase
        return s;
    endfunction

    // States that are stretched by memory wait cycles
    function automatic logic is_wait_state(state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Instruction-register fields in, datapath enables/selects out.
interface multicycle_ctrl_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       RegWrite, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
    logic       BranchNE, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, MemtoReg, PCSource;

    // Controller side
    modport master (
        input  opcode, funct3,
        output RegWrite, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
               BranchNE, Illegal, ALUSrcA, ALUSrcB, ALUOp, MemtoReg, PCSource
    );
    // Datapath side
    modport slave (
        output opcode, funct3,
        input  RegWrite, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
               BranchNE, Illegal, ALUSrcA, ALUSrcB, ALUOp, MemtoReg, PCSource
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_mem_wait_ctr.sv
// Wait-cycle counter for memory-access states. Counts from 0 up to MAX;
// done flags the last cycle of the state, done_nxt flags it one cycle
// early so the registered outputs can pulse on that last cycle.
module mem_wait_ctr #(
    parameter int unsigned MAX = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic done,
    output logic done_nxt
);
    localparam logic [3:0] MAX4 = 4'(MAX);

    logic [3:0] cnt_q, cnt_d;

    // Clear on state entry, otherwise advance while the state is held
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && !done)
            cnt_d = cnt_q + 4'd1;
    end

    assign done     = (cnt_q == MAX4);
    assign done_nxt = (cnt_d == MAX4);

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RISC-V core. Outputs are registered
// from the next state, so they line up with the state they describe and
// drop asynchronously on reset. run_q holds the FSM in FETCH for the first
// edge after reset so that edge starts the first FETCH cycle.
// Optional feature macro: CTRL_JUMP_EN (JAL/JALR support).
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input logic                  clk,
    input logic                  reset_n,
    multicycle_ctrl_fsm_if.master bus
);
    state_e    state_q, state_d;
    ctrl_out_t out_q, out_d;
    logic      run_q;
    logic      done, done_nxt, cnt_clr, cnt_en;

    assign cnt_en  = run_q && is_wait_state(state_q);
    assign cnt_clr = !run_q || (state_d != state_q);

    mem_wait_ctr #(.MAX(MEM_WAIT)) u_wait (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .done     (done),
        .done_nxt (done_nxt)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!run_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  if (done) state_d = S_DECODE;
                S_DECODE: state_d = decode_op(bus.opcode, bus.funct3);
                S_MEMADR: state_d = (bus.opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (done) state_d = S_MEMWB;
                S_MEMWR:  if (done) state_d = S_FETCH;
                S_EXEC_R, S_EXEC_I, S_LUI:   state_d = S_ALUWB;
                S_MEMWB, S_ALUWB, S_BRANCH:  state_d = S_FETCH;
`ifdef CTRL_JUMP_EN
                S_JAL, S_JALR:               state_d = S_FETCH;
`endif
                default:                     state_d = state_q;
            endcase
        end
    end

    // Moore decode of the state being entered
    always_comb begin
        out_d = '0;
        case (state_d)
            S_FETCH: begin
                out_d.mem_read  = 1'b1;
                out_d.alu_src_b = SRCB_FOUR;
                out_d.ir_write  = done_nxt;
                out_d.pc_write  = done_nxt;
            end
            S_DECODE: out_d.alu_src_b = SRCB_IMM;
            S_MEMADR: begin
                out_d.alu_src_a = SRCA_RS1;
                out_d.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                out_d.mem_read = 1'b1;
                out_d.iord     = 1'b1;
            end
            S_MEMWB: begin
                out_d.reg_write  = 1'b1;
                out_d.mem_to_reg = M2R_MDR;
            end
            S_MEMWR: begin
                out_d.mem_write = 1'b1;
                out_d.iord      = 1'b1;
            end
            S_EXEC_R: begin
                out_d.alu_src_a = SRCA_RS1;
                out_d.alu_op    = ALU_RTYPE;
            end
            S_EXEC_I: begin
                out_d.alu_src_a = SRCA_RS1;
                out_d.alu_src_b = SRCB_IMM;
                out_d.alu_op    = ALU_ITYPE;
            end
            S_LUI: begin
                out_d.alu_src_a = SRCA_ZERO;
                out_d.alu_src_b = SRCB_IMM;
            end
            S_ALUWB: out_d.reg_write = 1'b1;
            S_BRANCH: begin
                out_d.alu_src_a     = SRCA_RS1;
                out_d.alu_op        = ALU_SUB;
                out_d.pc_write_cond = 1'b1;
                out_d.pc_source     = PCSRC_ALUOUT;
                out_d.branch_ne     = bus.funct3[0];
            end
`ifdef CTRL_JUMP_EN
            S_JAL: begin
                out_d.pc_write   = 1'b1;
                out_d.pc_source  = PCSRC_ALUOUT;
                out_d.reg_write  = 1'b1;
                out_d.mem_to_reg = M2R_PC;
            end
            S_JALR: begin
                out_d.alu_src_a  = SRCA_RS1;
                out_d.alu_src_b  = SRCB_IMM;
                out_d.pc_write   = 1'b1;
                out_d.reg_write  = 1'b1;
                out_d.mem_to_reg = M2R_PC;
            end
`endif
            S_TRAP:  out_d.illegal = 1'b1;
            default: out_d = '0;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            out_q   <= out_d;
        end
    end

    assign bus.RegWrite    = out_q.reg_write;
    assign bus.MemRead     = out_q.mem_read;
    assign bus.MemWrite    = out_q.mem_write;
    assign bus.IorD        = out_q.iord;
    assign bus.IRWrite     = out_q.ir_write;
    assign bus.PCWrite     = out_q.pc_write;
    assign bus.PCWriteCond = out_q.pc_write_cond;
    assign bus.BranchNE    = out_q.branch_ne;
    assign bus.Illegal     = out_q.illegal;
    assign bus.ALUSrcA     = out_q.alu_src_a;
    assign bus.ALUSrcB     = out_q.alu_src_b;
    assign bus.ALUOp       = out_q.alu_op;
    assign bus.MemtoReg    = out_q.mem_to_reg;
    assign bus.PCSource    = out_q.pc_source;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: two instances (MEM_WAIT=0 and 2), a
// latency/trap vector table, hand-written corner sequences, and random
// instruction streams checked cycle by cycle against an instruction-level model.
module tb_multicycle_ctrl_fsm;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] op_r = '0;
    logic [2:0] f3_r = '0;

    multicycle_ctrl_fsm_if if0 ();
    multicycle_ctrl_fsm_if if2 ();
    assign if0.opcode = op_r;
    assign if0.funct3 = f3_r;
    assign if2.opcode = op_r;
    assign if2.funct3 = f3_r;

    multicycle_ctrl_fsm #(.MEM_WAIT(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.master));
    multicycle_ctrl_fsm #(.MEM_WAIT(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(if2.master));

    int checks = 0;
    int errors = 0;

    // {RegWrite,MemRead,MemWrite,IorD,IRWrite,PCWrite,PCWriteCond,BranchNE,Illegal,
    //  ALUSrcA,ALUSrcB,ALUOp,MemtoReg,PCSource}
    function automatic logic [18:0] v(bit rw, bit mr, bit mw, bit iord, bit irw, bit pcw,
                                      bit pcwc, bit bne, bit ill, logic [1:0] a,
                                      logic [1:0] b, logic [1:0] op, logic [1:0] m2r,
                                      logic [1:0] pcs);
        return {rw, mr, mw, iord, irw, pcw, pcwc, bne, ill, a, b, op, m2r, pcs};
    endfunction

    function automatic logic [18:0] get_out(int sel);
        if (sel == 0)
            return {if0.RegWrite, if0.MemRead, if0.MemWrite, if0.IorD, if0.IRWrite, if0.PCWrite,
                    if0.PCWriteCond, if0.BranchNE, if0.Illegal, if0.ALUSrcA, if0.ALUSrcB,
                    if0.ALUOp, if0.MemtoReg, if0.PCSource};
        return {if2.RegWrite, if2.MemRead, if2.MemWrite, if2.IorD, if2.IRWrite, if2.PCWrite,
                if2.PCWriteCond, if2.BranchNE, if2.Illegal, if2.ALUSrcA, if2.ALUSrcB,
                if2.ALUOp, if2.MemtoReg, if2.PCSource};
    endfunction

    function automatic int wait_of(int sel);
        return (sel == 0) ? 0 : 2;
    endfunction

    task automatic chk(string name, logic [18:0] act, logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    task automatic chk_i(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Instruction-level reference: the per-cycle output sequence an
    // instruction should produce, from its first FETCH cycle onward.
    logic [18:0] exp_q[$];

    function automatic bit build_exp(logic [6:0] op, logic [2:0] f3, int w);
        bit trap = 1'b0;
        exp_q.delete();
        for (int i = 0; i <= w; i++)
            exp_q.push_back(v(0,1,0,0, i == w, i == w, 0,0,0, 2'd0,2'd1,2'd0,2'd0,2'd0));
        exp_q.push_back(v(0,0,0,0,0,0,0,0,0, 2'd0,2'd2,2'd0,2'd0,2'd0));
        case (op)
            7'b0000011: begin
                exp_q.push_back(v(0,0,0,0,0,0,0,0,0, 2'd1,2'd2,2'd0,2'd0,2'd0));
                for (int i = 0; i <= w; i++)
                    exp_q.push_back(v(0,1,0,1,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0));
                exp_q.push_back(v(1,0,0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd1,2'd0));
            end
            7'b0100011: begin
                exp_q.push_back(v(0,0,0,0,0,0,0,0,0, 2'd1,2'd2,2'd0,2'd0,2'd0));
                for (int i = 0; i <= w; i++)
                    exp_q.push_back(v(0,0,1,1,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0));
            end
            7'b0110011: begin
                exp_q.push_back(v(0,0,0,0,0,0,0,0,0, 2'd1,2'd0,2'd2,2'd0,2'd0));
                exp_q.push_back(v(1,0,0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0));
            end
            7'b0010011: begin
                exp_q.push_back(v(0,0,0,0,0,0,0,0,0, 2'd1,2'd2,2'd3,2'd0,2'd0));
                exp_q.push_back(v(1,0,0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0));
            end
            7'b0110111: begin
                exp_q.push_back(v(0,0,0,0,0,0,0,0,0, 2'd2,2'd2,2'd0,2'd0,2'd0));
                exp_q.push_back(v(1,0,0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0));
            end
            7'b1100011: begin
                if (f3 == 3'b000 || f3 == 3'b001)
                    exp_q.push_back(v(0,0,0,0,0,0,1,f3[0],0, 2'd1,2'd0,2'd1,2'd0,2'd1));
                else
                    trap = 1'b1;
            end
`ifdef CTRL_JUMP_EN
            7'b1101111: exp_q.push_back(v(1,0,0,0,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd2,2'd1));
            7'b1100111: exp_q.push_back(v(1,0,0,0,0,1,0,0,0, 2'd1,2'd2,2'd0,2'd2,2'd0));
`endif
            default: trap = 1'b1;
        endcase
        return trap;
    endfunction

    // Pulse reset; returns at the falling edge inside the first FETCH cycle
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Run one instruction from its first FETCH cycle against the model
    task automatic run_instr(int sel, logic [6:0] op, logic [2:0] f3, string name);
        bit trap;
        op_r = op;
        f3_r = f3;
        trap = build_exp(op, f3, wait_of(sel));
        foreach (exp_q[k]) begin
            chk($sformatf("%s cyc%0d", name, k), get_out(sel), exp_q[k]);
            @(negedge clk);
        end
        if (trap) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("%s trap%0d", name, k), get_out(sel),
                    v(0,0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0,2'd0));
                @(negedge clk);
            end
            do_reset();
        end
    endtask

    // Cycles from FETCH start to next FETCH start, or to the first Illegal cycle
    task automatic measure(int sel, output int lat, output bit trapped);
        bit left = 1'b0;
        logic [18:0] o;
        lat = -1;
        trapped = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            o = get_out(sel);
            if (o[10]) begin
                trapped = 1'b1;
                lat = c;
                break;
            end
            if (!(o[17] && !o[15])) left = 1'b1;
            else if (left) begin
                lat = c;
                break;
            end
        end
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        int         sel;
        int         lat;
        bit         trap;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int lat;
        bit trapped;
        int mr_cnt, mw_cnt, ir_at, pcw_at, waited;
        logic [6:0] rop;
        logic [6:0] ops[8];

        tbl[0]  = '{7'b0000011, 3'd2, 0, 5, 0};
        tbl[1]  = '{7'b0000011, 3'd2, 1, 9, 0};
        tbl[2]  = '{7'b0100011, 3'd2, 0, 4, 0};
        tbl[3]  = '{7'b0100011, 3'd2, 1, 8, 0};
        tbl[4]  = '{7'b0110011, 3'd0, 0, 4, 0};
        tbl[5]  = '{7'b0010011, 3'd5, 1, 6, 0};
        tbl[6]  = '{7'b0110111, 3'd0, 0, 4, 0};
        tbl[7]  = '{7'b1100011, 3'd0, 0, 3, 0};
        tbl[8]  = '{7'b1100011, 3'd1, 1, 5, 0};
        tbl[9]  = '{7'b1100011, 3'd2, 0, 2, 1};
        tbl[10] = '{7'b1111111, 3'd0, 1, 4, 1};
`ifdef CTRL_JUMP_EN
        tbl[11] = '{7'b1101111, 3'd0, 0, 3, 0};
        tbl[12] = '{7'b1100111, 3'd0, 1, 5, 0};
`else
        tbl[11] = '{7'b1101111, 3'd0, 0, 2, 1};
        tbl[12] = '{7'b1100111, 3'd0, 1, 4, 1};
`endif
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b0110111, 7'b1101111, 7'b1100111};

        // Reset state, including across clock edges
        @(negedge clk);
        chk("reset w0", get_out(0), '0);
        chk("reset w2", get_out(1), '0);
        @(negedge clk);
        chk("reset held w2", get_out(1), '0);
        reset_n = 1'b1;
        #1 chk("release pre-edge", get_out(0), '0);
        @(negedge clk);
        chk("first fetch w0", get_out(0), v(0,1,0,0,1,1,0,0,0, 2'd0,2'd1,2'd0,2'd0,2'd0));

        // Latency / trap table
        foreach (tbl[i]) begin
            do_reset();
            op_r = tbl[i].op;
            f3_r = tbl[i].f3;
            measure(tbl[i].sel, lat, trapped);
            chk_i($sformatf("tbl%0d latency", i), lat, tbl[i].lat);
            chk_i($sformatf("tbl%0d trap", i), int'(trapped), int'(tbl[i].trap));
        end

        // LW, W=0: full cycle-by-cycle sequence
        do_reset();
        run_instr(0, 7'b0000011, 3'd2, "lw w0");
        // BNE and JALR sequences
        run_instr(0, 7'b1100011, 3'd1, "bne w0");
        run_instr(0, 7'b1100111, 3'd0, "jalr w0");

        // SW, W=2: stretched fetch and write
        do_reset();
        op_r = 7'b0100011;
        mr_cnt = 0; mw_cnt = 0; ir_at = -1; pcw_at = -1;
        for (int c = 0; c < 8; c++) begin
            if (if2.MemRead) mr_cnt++;
            if (if2.MemWrite) mw_cnt++;
            if (if2.IRWrite) ir_at = c;
            if (if2.PCWrite) pcw_at = c;
            @(negedge clk);
        end
        chk_i("sw w2 memread cycles", mr_cnt, 3);
        chk_i("sw w2 irwrite cycle", ir_at, 2);
        chk_i("sw w2 pcwrite cycle", pcw_at, 2);
        chk_i("sw w2 memwrite cycles", mw_cnt, 3);
        chk("sw w2 next fetch", get_out(1), v(0,1,0,0,0,0,0,0,0, 2'd0,2'd1,2'd0,2'd0,2'd0));

        // Illegal opcode: sticky for 20 cycles, cleared by reset
        do_reset();
        op_r = 7'b1111111;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("illegal hold %0d", c), get_out(0),
                v(0,0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0,2'd0));
            @(negedge clk);
        end
        do_reset();
        chk("post-trap fetch", get_out(0), v(0,1,0,0,1,1,0,0,0, 2'd0,2'd1,2'd0,2'd0,2'd0));

        // Reset asserted during MEMWR
        do_reset();
        op_r = 7'b0100011;
        waited = 0;
        while (!if2.MemWrite && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk_i("reach memwr", int'(if2.MemWrite), 1);
        #2 reset_n = 1'b0;
        #1 chk("abort memwr", get_out(1), '0);
        @(negedge clk);
        chk("abort held", get_out(1), '0);
        reset_n = 1'b1;
        #1 chk("abort release pre-edge", get_out(1), '0);
        @(negedge clk);
        chk("abort refetch", get_out(1), v(0,1,0,0,0,0,0,0,0, 2'd0,2'd1,2'd0,2'd0,2'd0));

        // Random instruction streams on both wait-state configurations
        for (int sel = 0; sel < 2; sel++) begin
            do_reset();
            for (int n = 0; n < 60; n++) begin
                if ($urandom_range(0, 8) == 8) rop = 7'($urandom);
                else                           rop = ops[$urandom_range(0, 7)];
                run_instr(sel, rop, 3'($urandom), $sformatf("rnd s%0d n%0d op%02h", sel, n, rop));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
